branch_resolve_bht: RTL

- Parametrised successor to the core's combinational branch-decision logic.
- Resolves BEQ/BNE/BLT/BGE/BLTU/BGEU/JAL/JALR in the execute stage and registers the outcome.
- Detects mispredicts against a fetch-side prediction and supplies the redirect PC.
- Owns a branch history table (BHT) of 2-bit saturating counters, which fetch reads for its prediction.

---
 rtl/branch_resolve_bht.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/branch_resolve_bht.sv
// ---------------------------------------------------------------------------
// branch_resolve_bht
//   Execute-stage branch/jump resolution with a registered outcome, mispredict
//   detection against the fetch-side prediction, and a branch history table
//   of 2-bit saturating counters that fetch reads for its prediction.
//
// Ports
//   clk, reset           : rising-edge clock, asynchronous active-low reset
//   fetch_pc             : fetch PC; pred_taken_o = MSB of its BHT counter
//   ex_valid, flush      : execute instruction valid / kill
//   ex_pc, ex_pred_taken : execute PC and the prediction it carried
//   rs1_val, rs2_val     : compare operands
//   fn3                  : one-hot funct3 (bit0 EQ, 1 NE, 4 LT, 5 GE, 6 LTU, 7 GEU)
//   branch_i, jal_i, jal_r_i, target_i : instruction class and target
//   res_valid_o, pc_next_sel, mispredict_o, redirect_pc_o : registered result
//
// Optional build macro
//   BRANCH_STATS_EN : adds saturating counters stat_branches_o and
//                     stat_mispred_o (accepted control instructions and
//                     accepted mispredicts).
// ---------------------------------------------------------------------------
module branch_resolve_bht #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned BHT_IDX  = 6,
  parameter logic [1:0]  CNT_INIT = 2'b01
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] fetch_pc,
  output logic            pred_taken_o,
  input  logic            ex_valid,
  input  logic [XLEN-1:0] ex_pc,
  input  logic            ex_pred_taken,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic [7:0]      fn3,
  input  logic            branch_i,
  input  logic            jal_i,
  input  logic            jal_r_i,
  input  logic [XLEN-1:0] target_i,
  input  logic            flush,
  output logic            res_valid_o,
  output logic            pc_next_sel,
  output logic            mispredict_o,
  output logic [XLEN-1:0] redirect_pc_o
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0]     stat_branches_o,
  output logic [31:0]     stat_mispred_o
`endif
);

  localparam int unsigned BHT_N = 1 << BHT_IDX;

  logic [1:0]         bht_q [BHT_N];
  logic [BHT_IDX-1:0] fetch_idx_s, ex_idx_s;
  logic               acc_s, eq_s, lt_s, ltu_s, cond_s, taken_s, mispred_s;
  logic [XLEN-1:0]    next_pc_s;
  logic [1:0]         cnt_cur_s, cnt_upd_s;
  logic               res_valid_q, res_valid_d;
  logic               taken_q, taken_d;
  logic               mispred_q, mispred_d;
  logic [XLEN-1:0]    redirect_q, redirect_d;
  logic               unused_s;

  assign fetch_idx_s  = fetch_pc[BHT_IDX+1:2];
  assign ex_idx_s     = ex_pc[BHT_IDX+1:2];
  // Read of the registered table: a same-cycle update is seen only next cycle.
  assign pred_taken_o = bht_q[fetch_idx_s][1];
  assign unused_s     = ^{fn3[3:2], fetch_pc[XLEN-1:BHT_IDX+2], fetch_pc[1:0]};

  // Compare, taken, redirect target and mispredict decision.
  always_comb begin
    acc_s   = ex_valid & ~flush;
    eq_s    = (rs1_val == rs2_val);
    lt_s    = ($signed(rs1_val) < $signed(rs2_val));
    ltu_s   = (rs1_val < rs2_val);
    // Non-one-hot fn3 ORs every enabled term; fn3 == 0 yields no condition.
    cond_s  = branch_i & ((fn3[0] & eq_s)  | (fn3[1] & ~eq_s) |
                          (fn3[4] & lt_s)  | (fn3[5] & ~lt_s) |
                          (fn3[6] & ltu_s) | (fn3[7] & ~ltu_s));
    taken_s = jal_i | jal_r_i | cond_s;
    if (jal_r_i) begin
      next_pc_s = {target_i[XLEN-1:1], 1'b0};
    end else if (taken_s) begin
      next_pc_s = target_i;
    end else begin
      next_pc_s = ex_pc + XLEN'(32'd4);
    end
    if (jal_r_i) begin
      mispred_s = 1'b1;
    end else if (jal_i) begin
      mispred_s = ~ex_pred_taken;
    end else if (branch_i) begin
      mispred_s = taken_s ^ ex_pred_taken;
    end else begin
      mispred_s = ex_pred_taken;
    end
  end

  // Saturating counter step for the execute-stage entry.
  always_comb begin
    cnt_cur_s = bht_q[ex_idx_s];
    if (cond_s) begin
      cnt_upd_s = (cnt_cur_s == 2'b11) ? 2'b11 : cnt_cur_s + 2'b01;
    end else begin
      cnt_upd_s = (cnt_cur_s == 2'b00) ? 2'b00 : cnt_cur_s - 2'b01;
    end
  end

  // Next-state of the result registers; redirect holds when nothing accepted.
  always_comb begin
    res_valid_d = acc_s;
    taken_d     = acc_s & taken_s;
    mispred_d   = acc_s & mispred_s;
    if (acc_s) begin
      redirect_d = next_pc_s;
    end else begin
      redirect_d = redirect_q;
    end
  end

  // Result registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      res_valid_q <= 1'b0;
      taken_q     <= 1'b0;
      mispred_q   <= 1'b0;
      redirect_q  <= '0;
    end else begin
      res_valid_q <= res_valid_d;
      taken_q     <= taken_d;
      mispred_q   <= mispred_d;
      redirect_q  <= redirect_d;
    end
  end

  // Branch history table; only accepted conditional branches train it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(BHT_N); i++) begin
        bht_q[i] <= CNT_INIT;
      end
    end else if (acc_s && branch_i) begin
      bht_q[ex_idx_s] <= cnt_upd_s;
    end
  end

  assign res_valid_o   = res_valid_q;
  assign pc_next_sel   = taken_q;
  assign mispredict_o  = mispred_q;
  assign redirect_pc_o = redirect_q;

`ifdef BRANCH_STATS_EN
  logic [31:0] stat_br_q, stat_br_d, stat_mp_q, stat_mp_d;

  // Saturating statistics next-state.
  always_comb begin
    if (acc_s && (branch_i || jal_i || jal_r_i) && (stat_br_q != 32'hFFFF_FFFF)) begin
      stat_br_d = stat_br_q + 32'd1;
    end else begin
      stat_br_d = stat_br_q;
    end
    if (acc_s && mispred_s && (stat_mp_q != 32'hFFFF_FFFF)) begin
      stat_mp_d = stat_mp_q + 32'd1;
    end else begin
      stat_mp_d = stat_mp_q;
    end
  end

  // Statistics registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_br_q <= 32'd0;
      stat_mp_q <= 32'd0;
    end else begin
      stat_br_q <= stat_br_d;
      stat_mp_q <= stat_mp_d;
    end
  end

  assign stat_branches_o = stat_br_q;
  assign stat_mispred_o  = stat_mp_q;
`endif

endmodule
